nmea_vtg_ctrl: RTL and testbench

NMEA_VTG_CTRL -- requirements
Module: nmea_vtg_ctrl

---
 rtl/nmea_pkg.sv | 30 +++
 rtl/nmea_dec_acc.sv | 45 ++++
 rtl/nmea_vtg_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_nmea_vtg_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/nmea_pkg.sv
// Shared NMEA parser types and ASCII constants.
// Latency: none (types/constants only); backpressure: n/a.
package nmea_pkg;

   typedef enum logic [2:0] {
      IDLE, HDR, FIELD, CK_HI, CK_LO, WAIT_EOL
   } state_t;

   typedef enum logic [1:0] {
      ERR_CKSUM   = 2'd0,
      ERR_OVERLEN = 2'd1,
      ERR_BADCHAR = 2'd2
   } err_code_t;

   localparam logic [7:0] ASC_DOLLAR = 8'h24;
   localparam logic [7:0] ASC_STAR   = 8'h2A;
   localparam logic [7:0] ASC_COMMA  = 8'h2C;
   localparam logic [7:0] ASC_DOT    = 8'h2E;
   localparam logic [7:0] ASC_CR     = 8'h0D;
   localparam logic [7:0] ASC_LF     = 8'h0A;

   localparam logic [7:0] VTG_HDR [5] = '{8'h47, 8'h50, 8'h56, 8'h54, 8'h47};
   localparam int         INT_SAT     = 655;
   localparam int         KMH_FIELD   = 7;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

endpackage

// File: rtl/nmea_dec_acc.sv
// Decimal accumulator: integer part saturating at 655, two fraction digits.
// Latency: result valid the cycle after the digit; backpressure: none, takes a digit every cycle.
module nmea_dec_acc
   import nmea_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       dig_vld_i,
   input  logic [3:0] dig_i,
   input  logic       dot_i,
   output logic [9:0] int_o,
   output logic [6:0] frac_o,
   output logic       frac_mode_o
);

   logic [1:0]  fcnt_q;
   logic [13:0] int_ext;

   assign int_ext = 14'(int_o) * 14'd10 + 14'(dig_i);

   always_ff @(posedge clk_i) begin
      if (!rst_i || clr_i) begin
         int_o       <= '0;
         frac_o      <= '0;
         frac_mode_o <= 1'b0;
         fcnt_q      <= '0;
      end else begin
         if (dot_i) frac_mode_o <= 1'b1;
         if (dig_vld_i) begin
            if (!frac_mode_o) begin
               int_o <= (int_ext > 14'(INT_SAT)) ? 10'(INT_SAT) : int_ext[9:0];
            end else if (fcnt_q == 2'd0) begin
               frac_o <= 7'(dig_i) * 7'd10;
               fcnt_q <= 2'd1;
            end else if (fcnt_q == 2'd1) begin
               // a third and later fraction digit is dropped, not rounded
               frac_o <= frac_o + 7'(dig_i);
               fcnt_q <= 2'd2;
            end
         end
      end
   end

endmodule

// File: rtl/nmea_vtg_ctrl.sv
// Parses $GPVTG sentences from a UART byte stream and reports km/h ground speed in 0.01 units.
// Latency: speed_valid_o rises the cycle after LF; backpressure: never stalls upstream, unconsumed results are overwritten.
module nmea_vtg_ctrl
   import nmea_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 82
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [15:0]           speed_o,
   output logic                  speed_valid_o,
   input  logic                  speed_ready_i,
   output logic                  err_o,
   output logic [1:0]            err_code_o,
   output logic                  overrun_o
);

   localparam int LEN_W = $clog2(MAX_LEN + 2);
   localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN + 1);

   state_t           state_q;
   logic [LEN_W-1:0] len_q, len_nxt;
   logic [2:0]       hdr_idx_q;
   logic [3:0]       comma_q;
   logic [7:0]       xor_q;
   logic [3:0]       ck_hi_q;
   logic             f7_seen_q;

   logic       take, overlen, in_f7, dig_ok, hex_ok;
   logic [3:0] hex_val;
   logic [7:0] hdr_ch;
   logic [9:0] acc_int;
   logic [6:0] acc_frac;
   logic       acc_frac_mode;
   logic [16:0] spd_full;
   logic [15:0] spd_sat;

   assign take     = valid_i & ready_o;
   assign len_nxt  = (len_q == LEN_LIMIT) ? len_q : len_q + LEN_W'(1);
   assign overlen  = (len_nxt == LEN_LIMIT);
   assign in_f7    = (state_q == FIELD) && (comma_q == 4'(KMH_FIELD))
                     && (data_i != ASC_COMMA) && (data_i != ASC_STAR);
   assign dig_ok   = is_digit(data_i);
   assign hdr_ch   = (hdr_idx_q < 3'd5) ? VTG_HDR[hdr_idx_q] : ASC_COMMA;
   assign spd_full = 17'(acc_int) * 17'd100 + 17'(acc_frac);
   assign spd_sat  = spd_full[16] ? 16'hFFFF : spd_full[15:0];

   always_comb begin
      hex_ok  = 1'b1;
      hex_val = data_i[3:0];
      if (dig_ok) begin
         hex_val = data_i[3:0];
      end else if ((data_i >= 8'h41 && data_i <= 8'h46) || (data_i >= 8'h61 && data_i <= 8'h66)) begin
         hex_val = data_i[3:0] + 4'd9;
      end else begin
         hex_ok = 1'b0;
      end
   end

   nmea_dec_acc u_acc (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (take && data_i == ASC_DOLLAR),
      .dig_vld_i   (take && in_f7 && dig_ok),
      .dig_i       (data_i[3:0]),
      .dot_i       (take && in_f7 && data_i == ASC_DOT && !acc_frac_mode),
      .int_o       (acc_int),
      .frac_o      (acc_frac),
      .frac_mode_o (acc_frac_mode)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q       <= IDLE;
         len_q         <= '0;
         hdr_idx_q     <= '0;
         comma_q       <= '0;
         xor_q         <= '0;
         ck_hi_q       <= '0;
         f7_seen_q     <= 1'b0;
         ready_o       <= 1'b0;
         speed_o       <= '0;
         speed_valid_o <= 1'b0;
         err_o         <= 1'b0;
         err_code_o    <= '0;
         overrun_o     <= 1'b0;
      end else begin
         ready_o   <= 1'b1;
         err_o     <= 1'b0;
         overrun_o <= 1'b0;
         if (speed_valid_o && speed_ready_i) speed_valid_o <= 1'b0;
         if (take) begin
            // '$' always starts a fresh sentence, whatever was in flight
            if (data_i == ASC_DOLLAR) begin
               state_q   <= HDR;
               len_q     <= LEN_W'(1);
               hdr_idx_q <= '0;
               comma_q   <= '0;
               xor_q     <= '0;
               f7_seen_q <= 1'b0;
            end else if (state_q != IDLE) begin
               len_q <= len_nxt;
               if (overlen) begin
                  state_q    <= IDLE;
                  err_o      <= 1'b1;
                  err_code_o <= ERR_OVERLEN;
               end else begin
                  case (state_q)
                     HDR: begin
                        xor_q <= xor_q ^ data_i;
                        if (data_i != hdr_ch) begin
                           state_q <= IDLE;
                        end else if (hdr_idx_q == 3'd5) begin
                           state_q <= FIELD;
                           comma_q <= 4'd1;
                        end else begin
                           hdr_idx_q <= hdr_idx_q + 3'd1;
                        end
                     end
                     FIELD: begin
                        if (data_i == ASC_STAR) begin
                           state_q <= CK_HI;
                        end else begin
                           xor_q <= xor_q ^ data_i;
                           if (data_i == ASC_COMMA) begin
                              if (comma_q != 4'd15) comma_q <= comma_q + 4'd1;
                           end else if (in_f7) begin
                              f7_seen_q <= 1'b1;
                              if (!dig_ok && !(data_i == ASC_DOT && !acc_frac_mode)) begin
                                 state_q    <= IDLE;
                                 err_o      <= 1'b1;
                                 err_code_o <= ERR_BADCHAR;
                              end
                           end
                        end
                     end
                     CK_HI: begin
                        if (hex_ok) begin
                           ck_hi_q <= hex_val;
                           state_q <= CK_LO;
                        end else begin
                           state_q    <= IDLE;
                           err_o      <= 1'b1;
                           err_code_o <= ERR_BADCHAR;
                        end
                     end
                     CK_LO: begin
                        if (!hex_ok || {ck_hi_q, hex_val} != xor_q) begin
                           state_q    <= IDLE;
                           err_o      <= 1'b1;
                           err_code_o <= hex_ok ? ERR_CKSUM : ERR_BADCHAR;
                        end else begin
                           state_q <= WAIT_EOL;
                        end
                     end
                     WAIT_EOL: begin
                        if (data_i == ASC_LF) begin
                           state_q <= IDLE;
                           // an empty km/h field yields no result and no error
                           if (f7_seen_q) begin
                              speed_o       <= spd_sat;
                              speed_valid_o <= 1'b1;
                              overrun_o     <= speed_valid_o && !speed_ready_i;
                           end
                        end else if (data_i != ASC_CR) begin
                           state_q    <= IDLE;
                           err_o      <= 1'b1;
                           err_code_o <= ERR_BADCHAR;
                        end
                     end
                     default: state_q <= IDLE;
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_nmea_vtg_ctrl.sv
// Directed self-checking bench for nmea_vtg_ctrl.
module tb_nmea_vtg_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [7:0]  data_i = '0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [15:0] speed_o;
   logic        speed_valid_o;
   logic        speed_ready_i = 1'b1;
   logic        err_o;
   logic [1:0]  err_code_o;
   logic        overrun_o;

   int n_cmp = 0;
   int n_fail = 0;
   int err_cnt = 0, rise_cnt = 0, ovr_cnt = 0;
   int e0, r0, o0;
   logic sv_q = 1'b0;

   localparam string S033 = "$GPVTG,0.00,T,,M,0.00,N,0.00,K,N*32\r\n";
   localparam string S033_BAD = "$GPVTG,0.00,T,,M,0.00,N,0.00,K,N*33\r\n";

   nmea_vtg_ctrl dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .data_i        (data_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .speed_o       (speed_o),
      .speed_valid_o (speed_valid_o),
      .speed_ready_i (speed_ready_i),
      .err_o         (err_o),
      .err_code_o    (err_code_o),
      .overrun_o     (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (err_o) err_cnt++;
      if (overrun_o) ovr_cnt++;
      if (speed_valid_o && !sv_q) rise_cnt++;
      sv_q = speed_valid_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      data_i  = b;
      valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic snap();
      e0 = err_cnt;
      r0 = rise_cnt;
      o0 = ovr_cnt;
   endtask

   function automatic string mk(input string body);
      logic [7:0] ck = '0;
      for (int i = 0; i < body.len(); i++) ck ^= body[i];
      return $sformatf("$%s*%02X\r\n", body, ck);
   endfunction

   function automatic string vtg(input string kmh);
      return mk({"GPVTG,0.00,T,,M,0.00,N,", kmh, ",K,N"});
   endfunction

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ready"}, 32'(ready_o), 0);
      check({tag, "_speed"}, 32'(speed_o), 0);
      check({tag, "_valid"}, 32'(speed_valid_o), 0);
      check({tag, "_err"}, 32'(err_o), 0);
      check({tag, "_code"}, 32'(err_code_o), 0);
      check({tag, "_ovr"}, 32'(overrun_o), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      check_outputs_zero("reset");
      rst_i = 1'b1;
      idle(1);
      check("ready_after_rst", 32'(ready_o), 1);

      // reference all-zero sentence, result one cycle after LF
      snap();
      send_str(S033);
      check("zero_valid_lat", 32'(speed_valid_o), 1);
      check("zero_speed", 32'(speed_o), 0);
      idle(3);
      check("zero_rises", 32'(rise_cnt - r0), 1);
      check("zero_errs", 32'(err_cnt - e0), 0);
      check("zero_valid_clr", 32'(speed_valid_o), 0);

      send_str(vtg("123.456"));
      check("s123_valid", 32'(speed_valid_o), 1);
      check("s123_speed", 32'(speed_o), 12345);
      idle(2);
      send_str(vtg("7"));
      check("s7_speed", 32'(speed_o), 700);
      idle(2);
      send_str(vtg("999.9"));
      check("s999_speed", 32'(speed_o), 65535);
      idle(2);

      snap();
      send_str(vtg("1.2.3"));
      idle(3);
      check("dot2_errs", 32'(err_cnt - e0), 1);
      check("dot2_code", 32'(err_code_o), 2);
      check("dot2_rises", 32'(rise_cnt - r0), 0);

      snap();
      send_str(S033_BAD);
      idle(3);
      check("ck_errs", 32'(err_cnt - e0), 1);
      check("ck_code", 32'(err_code_o), 0);
      check("ck_rises", 32'(rise_cnt - r0), 0);

      snap();
      send_str(mk("GPGGA,123519,4807.038,N"));
      send_str(S033);
      idle(3);
      check("gga_errs", 32'(err_cnt - e0), 0);
      check("gga_rises", 32'(rise_cnt - r0), 1);
      check("gga_speed", 32'(speed_o), 0);

      snap();
      send_str("$GPVTG,");
      repeat (90) send_byte(8'h41);
      idle(3);
      check("olen_errs", 32'(err_cnt - e0), 1);
      check("olen_code", 32'(err_code_o), 1);
      check("olen_rises", 32'(rise_cnt - r0), 0);

      snap();
      send_str(vtg(""));
      idle(3);
      check("empty_errs", 32'(err_cnt - e0), 0);
      check("empty_rises", 32'(rise_cnt - r0), 0);

      // consumer stalled: second result overwrites the first
      speed_ready_i = 1'b0;
      snap();
      send_str(vtg("5.00"));
      send_str(vtg("6.00"));
      idle(3);
      check("ovr_pulses", 32'(ovr_cnt - o0), 1);
      check("ovr_speed", 32'(speed_o), 600);
      check("ovr_valid", 32'(speed_valid_o), 1);
      check("ovr_rises", 32'(rise_cnt - r0), 1);
      speed_ready_i = 1'b1;
      idle(1);
      check("ovr_valid_clr", 32'(speed_valid_o), 0);

      // reset while a result is pending and a sentence is half received
      speed_ready_i = 1'b0;
      send_str(vtg("7"));
      send_str("$GPVTG,0.00,T,,M,0.00,N,12");
      rst_i = 1'b0;
      idle(2);
      check_outputs_zero("midrst");
      rst_i = 1'b1;
      speed_ready_i = 1'b1;
      idle(1);
      snap();
      send_str(vtg("123.456"));
      check("post_rst_valid", 32'(speed_valid_o), 1);
      check("post_rst_speed", 32'(speed_o), 12345);
      idle(3);
      check("post_rst_rises", 32'(rise_cnt - r0), 1);
      check("post_rst_errs", 32'(err_cnt - e0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
